inst_fetch: RTL and testbench

- PC register and instruction-fetch stage directly upstream of the datapath mux block.
- Holds current_pc and issues a request/ready read to instruction memory.
- Latches the returned instruction word and slices it into the immediate and shift fields the datapath muxes consume.
- Loads the datapath's computed next_pc under controller command.

---
 rtl/inst_fetch.sv | 173 +++++++++++++++++
 tb/tb_inst_fetch.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
//   Program counter and instruction-fetch stage. It holds the current PC,
//   issues a request/ready read to instruction memory, latches the returned
//   word into the instruction register, and slices that register into the
//   immediate / sub-op fields consumed by the downstream datapath mux stage.
//   The controller loads a new PC from the datapath (next_pc) via pc_load.
// ---------------------------------------------------------------------------
module inst_fetch #(
   parameter int                  AddrSize  = 10,
   parameter int                  DataSize  = 32,
   parameter logic [AddrSize-1:0] ResetPc   = {AddrSize{1'b0}},
   parameter int                  CountSize = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable_fetch,
   input  logic                 pc_load,
   input  logic [AddrSize-1:0]  next_pc,
   output logic                 im_req,
   output logic [AddrSize-1:0]  im_addr,
   input  logic [DataSize-1:0]  im_rdata,
   input  logic                 im_ready,
   output logic [AddrSize-1:0]  current_pc,
   output logic [DataSize-1:0]  instruction,
   output logic                 ir_valid,
   output logic                 busy,
   output logic [4:0]           imm_5bit,
   output logic [13:0]          imm_14bit,
   output logic [14:0]          imm_15bit,
   output logic [19:0]          imm_20bit,
   output logic [23:0]          imm_24bit,
   output logic [1:0]           sub_op_sv,
   output logic [CountSize-1:0] fetch_count
);

   // IDLE: no word wanted; REQ: read outstanding; VALID: word held in IR.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_VALID = 2'd2
   } state_t;

   // Saturating increment: the counter sticks at all-ones instead of wrapping
   // so a long-running system never reports a misleadingly small count.
   function automatic logic [CountSize-1:0] sat_inc(input logic [CountSize-1:0] value);
      logic [CountSize-1:0] result;
      if (value == {CountSize{1'b1}}) begin
         result = value;
      end else begin
         result = value + {{(CountSize-1){1'b0}}, 1'b1};
      end
      return result;
   endfunction

   state_t                state_r;
   state_t                state_nxt_s;
   logic [AddrSize-1:0]   pc_r;
   logic [AddrSize-1:0]   pc_nxt_s;
   logic [DataSize-1:0]   instr_r;
   logic [DataSize-1:0]   instr_nxt_s;
   logic                  ir_valid_r;
   logic                  ir_valid_nxt_s;
   logic                  im_req_r;
   logic                  im_req_nxt_s;
   logic [CountSize-1:0]  count_r;
   logic [CountSize-1:0]  count_nxt_s;

   // Next-state and next-register-value decode for the fetch controller.
   always_comb begin
      state_nxt_s    = state_r;
      pc_nxt_s       = pc_r;
      instr_nxt_s    = instr_r;
      ir_valid_nxt_s = ir_valid_r;
      count_nxt_s    = count_r;

      case (state_r)
         ST_IDLE: begin
            // A simultaneous load and fetch land on the same edge, so the
            // first REQ cycle already presents the newly loaded PC.
            if (pc_load) begin
               pc_nxt_s = next_pc;
            end else begin
               pc_nxt_s = pc_r;
            end
            if (enable_fetch) begin
               state_nxt_s = ST_REQ;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end

         ST_REQ: begin
            // Address is frozen here: pc_load/enable_fetch are not honoured
            // until the outstanding read has returned.
            if (im_ready) begin
               instr_nxt_s    = im_rdata;
               ir_valid_nxt_s = 1'b1;
               count_nxt_s    = sat_inc(count_r);
               state_nxt_s    = ST_VALID;
            end else begin
               state_nxt_s    = ST_REQ;
            end
         end

         ST_VALID: begin
            if (pc_load) begin
               pc_nxt_s       = next_pc;
               ir_valid_nxt_s = 1'b0;
               if (enable_fetch) begin
                  state_nxt_s = ST_REQ;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end else if (enable_fetch) begin
               ir_valid_nxt_s = 1'b0;
               state_nxt_s    = ST_REQ;
            end else begin
               state_nxt_s    = ST_VALID;
            end
         end

         default: begin
            // Unreachable encoding: recover to a quiet, empty stage.
            state_nxt_s    = ST_IDLE;
            ir_valid_nxt_s = 1'b0;
         end
      endcase

      // Request is a registered copy of "we will be in REQ next cycle".
      if (state_nxt_s == ST_REQ) begin
         im_req_nxt_s = 1'b1;
      end else begin
         im_req_nxt_s = 1'b0;
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         pc_r       <= ResetPc;
         instr_r    <= {DataSize{1'b0}};
         ir_valid_r <= 1'b0;
         im_req_r   <= 1'b0;
         count_r    <= {CountSize{1'b0}};
      end else begin
         state_r    <= state_nxt_s;
         pc_r       <= pc_nxt_s;
         instr_r    <= instr_nxt_s;
         ir_valid_r <= ir_valid_nxt_s;
         im_req_r   <= im_req_nxt_s;
         count_r    <= count_nxt_s;
      end
   end

   assign current_pc  = pc_r;
   assign im_addr     = pc_r;
   assign im_req      = im_req_r;
   assign instruction = instr_r;
   assign ir_valid    = ir_valid_r;
   assign fetch_count = count_r;
   assign busy        = (state_r == ST_REQ);

   // Raw field slices of the IR; any sign/zero extension is done downstream.
   assign imm_5bit  = instr_r[14:10];
   assign imm_14bit = instr_r[13:0];
   assign imm_15bit = instr_r[14:0];
   assign imm_20bit = instr_r[19:0];
   assign imm_24bit = instr_r[23:0];
   assign sub_op_sv = instr_r[9:8];

endmodule

// File: tb/tb_inst_fetch.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch
//   Directed bench for inst_fetch. A default-width instance and a second
//   instance with a 2-bit fetch counter share all stimulus; the second one
//   exposes counter saturation.
// ---------------------------------------------------------------------------
module tb_inst_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable_fetch;
   logic        pc_load;
   logic [9:0]  next_pc;
   logic [31:0] im_rdata;
   logic        im_ready;

   logic        im_req;
   logic [9:0]  im_addr;
   logic [9:0]  current_pc;
   logic [31:0] instruction;
   logic        ir_valid;
   logic        busy;
   logic [4:0]  imm_5bit;
   logic [13:0] imm_14bit;
   logic [14:0] imm_15bit;
   logic [19:0] imm_20bit;
   logic [23:0] imm_24bit;
   logic [1:0]  sub_op_sv;
   logic [15:0] fetch_count;

   logic        s_im_req;
   logic [9:0]  s_im_addr;
   logic [9:0]  s_current_pc;
   logic [31:0] s_instruction;
   logic        s_ir_valid;
   logic        s_busy;
   logic [4:0]  s_imm_5bit;
   logic [13:0] s_imm_14bit;
   logic [14:0] s_imm_15bit;
   logic [19:0] s_imm_20bit;
   logic [23:0] s_imm_24bit;
   logic [1:0]  s_sub_op_sv;
   logic [1:0]  s_fetch_count;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   inst_fetch #(.AddrSize(10), .DataSize(32), .ResetPc(10'd0), .CountSize(16)) dut (
      .clk(clk), .rst(rst), .enable_fetch(enable_fetch), .pc_load(pc_load),
      .next_pc(next_pc), .im_req(im_req), .im_addr(im_addr), .im_rdata(im_rdata),
      .im_ready(im_ready), .current_pc(current_pc), .instruction(instruction),
      .ir_valid(ir_valid), .busy(busy), .imm_5bit(imm_5bit), .imm_14bit(imm_14bit),
      .imm_15bit(imm_15bit), .imm_20bit(imm_20bit), .imm_24bit(imm_24bit),
      .sub_op_sv(sub_op_sv), .fetch_count(fetch_count)
   );

   inst_fetch #(.AddrSize(10), .DataSize(32), .ResetPc(10'd0), .CountSize(2)) dut_sat (
      .clk(clk), .rst(rst), .enable_fetch(enable_fetch), .pc_load(pc_load),
      .next_pc(next_pc), .im_req(s_im_req), .im_addr(s_im_addr), .im_rdata(im_rdata),
      .im_ready(im_ready), .current_pc(s_current_pc), .instruction(s_instruction),
      .ir_valid(s_ir_valid), .busy(s_busy), .imm_5bit(s_imm_5bit), .imm_14bit(s_imm_14bit),
      .imm_15bit(s_imm_15bit), .imm_20bit(s_imm_20bit), .imm_24bit(s_imm_24bit),
      .sub_op_sv(s_sub_op_sv), .fetch_count(s_fetch_count)
   );

   // Advance one clock and settle just after the rising edge.
   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Two reset cycles with all controls quiet.
   task automatic do_reset;
      rst = 1'b1; enable_fetch = 1'b0; pc_load = 1'b0; next_pc = 10'd0;
      im_ready = 1'b0; im_rdata = 32'd0;
      step; step;
      rst = 1'b0;
   endtask

   task automatic test_reset;
      do_reset;
      checks++; if (current_pc !== 10'd0) begin errors++; $display("FAIL reset_pc got=%h exp=%h", current_pc, 10'd0); end
      checks++; if (im_req !== 1'b0) begin errors++; $display("FAIL reset_im_req got=%b exp=0", im_req); end
      checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL reset_ir_valid got=%b exp=0", ir_valid); end
      checks++; if (fetch_count !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", fetch_count); end
      checks++; if (instruction !== 32'd0) begin errors++; $display("FAIL reset_instr got=%h exp=0", instruction); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (s_fetch_count !== 2'd0) begin errors++; $display("FAIL reset_count2 got=%0d exp=0", s_fetch_count); end
   endtask

   task automatic test_idle;
      // im_ready while idle must not capture anything
      im_ready = 1'b1; im_rdata = 32'hFFFF_FFFF;
      step;
      checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL idle_ready_valid got=%b exp=0", ir_valid); end
      checks++; if (instruction !== 32'd0) begin errors++; $display("FAIL idle_ready_instr got=%h exp=0", instruction); end
      checks++; if (fetch_count !== 16'd0) begin errors++; $display("FAIL idle_ready_count got=%0d exp=0", fetch_count); end
      checks++; if (im_req !== 1'b0) begin errors++; $display("FAIL idle_ready_req got=%b exp=0", im_req); end
      // load + fetch together: first REQ cycle shows the new PC
      pc_load = 1'b1; next_pc = 10'h3FF; enable_fetch = 1'b1; im_ready = 1'b0;
      step;
      pc_load = 1'b0; enable_fetch = 1'b0;
      checks++; if (current_pc !== 10'h3FF) begin errors++; $display("FAIL idle_both_pc got=%h exp=3ff", current_pc); end
      checks++; if (im_addr !== 10'h3FF) begin errors++; $display("FAIL idle_both_addr got=%h exp=3ff", im_addr); end
      checks++; if (im_req !== 1'b1) begin errors++; $display("FAIL idle_both_req got=%b exp=1", im_req); end
   endtask

   task automatic test_zero_wait;
      do_reset;
      enable_fetch = 1'b1; im_ready = 1'b1; im_rdata = 32'h4C0A_2A5B;
      step;
      enable_fetch = 1'b0;
      checks++; if (im_req !== 1'b1) begin errors++; $display("FAIL zw_req_c1 got=%b exp=1", im_req); end
      checks++; if (im_addr !== 10'd0) begin errors++; $display("FAIL zw_addr_c1 got=%h exp=0", im_addr); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL zw_busy_c1 got=%b exp=1", busy); end
      checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL zw_valid_c1 got=%b exp=0", ir_valid); end
      step;
      im_ready = 1'b0;
      checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL zw_valid_c2 got=%b exp=1", ir_valid); end
      checks++; if (im_req !== 1'b0) begin errors++; $display("FAIL zw_req_c2 got=%b exp=0", im_req); end
      checks++; if (instruction !== 32'h4C0A_2A5B) begin errors++; $display("FAIL zw_instr got=%h exp=4c0a2a5b", instruction); end
      checks++; if (imm_5bit !== 5'h0A) begin errors++; $display("FAIL zw_imm5 got=%h exp=0a", imm_5bit); end
      checks++; if (sub_op_sv !== 2'b10) begin errors++; $display("FAIL zw_subop got=%b exp=10", sub_op_sv); end
      checks++; if (imm_14bit !== 14'h2A5B) begin errors++; $display("FAIL zw_imm14 got=%h exp=2a5b", imm_14bit); end
      checks++; if (imm_15bit !== 15'h2A5B) begin errors++; $display("FAIL zw_imm15 got=%h exp=2a5b", imm_15bit); end
      checks++; if (imm_20bit !== 20'hA2A5B) begin errors++; $display("FAIL zw_imm20 got=%h exp=a2a5b", imm_20bit); end
      checks++; if (imm_24bit !== 24'h0A2A5B) begin errors++; $display("FAIL zw_imm24 got=%h exp=0a2a5b", imm_24bit); end
      checks++; if (fetch_count !== 16'd1) begin errors++; $display("FAIL zw_count got=%0d exp=1", fetch_count); end
      step;
      checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL zw_hold_valid got=%b exp=1", ir_valid); end
      checks++; if (instruction !== 32'h4C0A_2A5B) begin errors++; $display("FAIL zw_hold_instr got=%h exp=4c0a2a5b", instruction); end
   endtask

   // Continues from the VALID state left by test_zero_wait.
   task automatic test_wait_states;
      enable_fetch = 1'b1; im_ready = 1'b0; im_rdata = 32'h1234_5678;
      step;
      enable_fetch = 1'b0; pc_load = 1'b1; next_pc = 10'h040;
      for (int i = 0; i < 4; i++) begin
         im_ready = (i == 3) ? 1'b1 : 1'b0;
         checks++; if (im_req !== 1'b1) begin errors++; $display("FAIL ws_req[%0d] got=%b exp=1", i, im_req); end
         checks++; if (im_addr !== 10'd0) begin errors++; $display("FAIL ws_addr[%0d] got=%h exp=0", i, im_addr); end
         checks++; if (current_pc !== 10'd0) begin errors++; $display("FAIL ws_pc[%0d] got=%h exp=0", i, current_pc); end
         checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL ws_valid[%0d] got=%b exp=0", i, ir_valid); end
         checks++; if (instruction !== 32'h4C0A_2A5B) begin errors++; $display("FAIL ws_instr[%0d] got=%h exp=4c0a2a5b", i, instruction); end
         step;
      end
      pc_load = 1'b0; im_ready = 1'b0;
      checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL ws_valid_end got=%b exp=1", ir_valid); end
      checks++; if (instruction !== 32'h1234_5678) begin errors++; $display("FAIL ws_instr_end got=%h exp=12345678", instruction); end
      checks++; if (fetch_count !== 16'd2) begin errors++; $display("FAIL ws_count got=%0d exp=2", fetch_count); end
      checks++; if (current_pc !== 10'd0) begin errors++; $display("FAIL ws_pc_end got=%h exp=0", current_pc); end
      checks++; if (im_req !== 1'b0) begin errors++; $display("FAIL ws_req_end got=%b exp=0", im_req); end
   endtask

   task automatic test_back_to_back;
      do_reset;
      enable_fetch = 1'b1; im_ready = 1'b1; im_rdata = 32'h0000_0001;
      step;
      enable_fetch = 1'b0;
      step;
      pc_load = 1'b1; enable_fetch = 1'b1; next_pc = 10'h004; im_ready = 1'b0; im_rdata = 32'hDEAD_BEEF;
      step;
      pc_load = 1'b0; enable_fetch = 1'b0; im_ready = 1'b1;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got=%b exp=1", busy); end
      checks++; if (im_req !== 1'b1) begin errors++; $display("FAIL b2b_req got=%b exp=1", im_req); end
      checks++; if (im_addr !== 10'h004) begin errors++; $display("FAIL b2b_addr got=%h exp=004", im_addr); end
      checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid got=%b exp=0", ir_valid); end
      step;
      im_ready = 1'b0;
      checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid2 got=%b exp=1", ir_valid); end
      checks++; if (instruction !== 32'hDEAD_BEEF) begin errors++; $display("FAIL b2b_instr got=%h exp=deadbeef", instruction); end
      checks++; if (fetch_count !== 16'd2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", fetch_count); end
      // load without fetch from VALID returns to IDLE at the new PC
      pc_load = 1'b1; next_pc = 10'h155;
      step;
      pc_load = 1'b0;
      checks++; if (current_pc !== 10'h155) begin errors++; $display("FAIL ld_pc got=%h exp=155", current_pc); end
      checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL ld_valid got=%b exp=0", ir_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ld_busy got=%b exp=0", busy); end
      checks++; if (im_req !== 1'b0) begin errors++; $display("FAIL ld_req got=%b exp=0", im_req); end
   endtask

   task automatic test_reset_mid_fetch;
      do_reset;
      pc_load = 1'b1; next_pc = 10'h010;
      step;
      pc_load = 1'b0; enable_fetch = 1'b1; im_ready = 1'b0;
      step;
      enable_fetch = 1'b0;
      checks++; if (im_addr !== 10'h010) begin errors++; $display("FAIL rmf_addr got=%h exp=010", im_addr); end
      checks++; if (im_req !== 1'b1) begin errors++; $display("FAIL rmf_req got=%b exp=1", im_req); end
      rst = 1'b1;
      step;
      rst = 1'b0; im_ready = 1'b1; im_rdata = 32'hCAFE_F00D;
      checks++; if (im_req !== 1'b0) begin errors++; $display("FAIL rmf_req_rst got=%b exp=0", im_req); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmf_busy_rst got=%b exp=0", busy); end
      checks++; if (current_pc !== 10'd0) begin errors++; $display("FAIL rmf_pc_rst got=%h exp=0", current_pc); end
      step;
      im_ready = 1'b0;
      checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL rmf_valid got=%b exp=0", ir_valid); end
      checks++; if (instruction !== 32'd0) begin errors++; $display("FAIL rmf_instr got=%h exp=0", instruction); end
      checks++; if (fetch_count !== 16'd0) begin errors++; $display("FAIL rmf_count got=%0d exp=0", fetch_count); end
      checks++; if (im_req !== 1'b0) begin errors++; $display("FAIL rmf_req_after got=%b exp=0", im_req); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmf_busy_after got=%b exp=0", busy); end
   endtask

   task automatic test_saturation;
      logic [1:0] exp_sat [5];
      exp_sat = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      do_reset;
      for (int k = 0; k < 5; k++) begin
         enable_fetch = 1'b1; im_ready = 1'b1; im_rdata = 32'(k);
         step;
         enable_fetch = 1'b0;
         step;
         checks++; if (s_fetch_count !== exp_sat[k]) begin errors++; $display("FAIL sat_count2[%0d] got=%0d exp=%0d", k, s_fetch_count, exp_sat[k]); end
         checks++; if (fetch_count !== 16'(k + 1)) begin errors++; $display("FAIL sat_count16[%0d] got=%0d exp=%0d", k, fetch_count, k + 1); end
      end
      im_ready = 1'b0;
   endtask

   initial begin
      test_reset;
      test_idle;
      test_zero_wait;
      test_wait_states;
      test_back_to_back;
      test_reset_mid_fetch;
      test_saturation;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Guard against a hung run.
   initial begin
      #200000;
      $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule
